// File: rtl/dehaze_pkg.sv
// Shared widths, transmission floor and output clamp for the dehaze pipeline.
// The saturation front end imports the same package.
package dehaze_pkg;

   localparam int unsigned PIX_W     = 8;
   localparam int unsigned T_W       = 12;
   localparam int unsigned INV_W     = 12;
   localparam int unsigned INV_FRAC  = 8;
   localparam int unsigned TMIN_DEF  = 410;
   localparam int unsigned RECIP_NUM = 2 ** (T_W + INV_FRAC);
   localparam int unsigned P_W       = (PIX_W + 1) + (INV_W + 1);
   localparam int unsigned Q_W       = 14;

   function automatic logic [PIX_W-1:0] clamp8(input logic signed [Q_W-1:0] q);
      if (q < 0)
         return '0;
      else if (q > 255)
         return '1;
      else
         return q[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/dehaze_recover_recip_lut.sv
// Reciprocal ROM: floor(2^20 / t) in Q4.8 for a Q0.12 transmission, registered read.
// Addresses below the floor are never looked up and hold the floor's reciprocal.
module recip_lut
   import dehaze_pkg::*;
#(
   parameter int unsigned TMIN = TMIN_DEF
) (
   input  logic             i_clk,
   input  logic             en,
   input  logic [T_W-1:0]   addr,
   output logic [INV_W-1:0] data
);

   localparam int unsigned FILL = RECIP_NUM / TMIN;

   logic [INV_W-1:0] rom [2**T_W];

   // Contents are elaborated as constants in place of a loaded image file.
   for (genvar g = 0; g < 2**T_W; g++) begin : g_rom
      if (g < TMIN) begin : g_fill
         assign rom[g] = FILL[INV_W-1:0];
      end else begin : g_val
         localparam int unsigned V = RECIP_NUM / g;
         assign rom[g] = V[INV_W-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (en)
         data <= rom[addr];
   end

endmodule

// File: rtl/dehaze_recover.sv
// Scene-radiance recovery: J = A + (I - A) / max(t, TMIN), clamped to 8 bits.
// Four-stage pipe with a single global advance, plus frame-length checking.
module dehaze_recover
   import dehaze_pkg::*;
#(
   parameter int unsigned TMIN      = TMIN_DEF,
   parameter int unsigned FRAME_PIX = 65536,
   parameter int unsigned CNT_W     = 17
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] red_pixel,
   input  logic [PIX_W-1:0] green_pixel,
   input  logic [PIX_W-1:0] blue_pixel,
   input  logic [PIX_W-1:0] ar,
   input  logic [PIX_W-1:0] ag,
   input  logic [PIX_W-1:0] ab,
   input  logic [T_W-1:0]   t_est,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [PIX_W-1:0] o_red,
   output logic [PIX_W-1:0] o_green,
   output logic [PIX_W-1:0] o_blue,
   output logic             m_last,
   output logic             o_frame_done,
   output logic             o_len_err
);

   localparam logic [T_W-1:0]   TMIN_T   = T_W'(TMIN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);

   logic                    adv;
   logic [3:0]              vld;
   logic [3:0]              lst;
   logic [T_W-1:0]          t1;
   logic [PIX_W-1:0]        i1 [3];
   logic [PIX_W-1:0]        a1 [3];
   logic [PIX_W-1:0]        a2 [3];
   logic [PIX_W-1:0]        a3 [3];
   logic signed [PIX_W:0]   d2 [3];
   logic signed [P_W-1:0]   p3 [3];
   logic signed [Q_W-1:0]   q4 [3];
   logic [INV_W-1:0]        inv;
   logic [CNT_W-1:0]        cnt;

   assign adv     = ~vld[3] | m_ready;
   assign s_ready = adv;
   assign m_valid = vld[3];
   assign m_last  = lst[3];

   // Read happens on the S1->S2 edge, so inv lines up with d2.
   recip_lut #(
      .TMIN (TMIN)
   ) u_recip_lut (
      .i_clk (i_clk),
      .en    (adv),
      .addr  (t1),
      .data  (inv)
   );

   always_comb begin
      for (int unsigned c = 0; c < 3; c++)
         q4[c] = Q_W'(p3[c] >>> INV_FRAC) + Q_W'($signed({1'b0, a3[c]}));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld     <= '0;
         lst     <= '0;
         t1      <= '0;
         o_red   <= '0;
         o_green <= '0;
         o_blue  <= '0;
         for (int unsigned c = 0; c < 3; c++) begin
            i1[c] <= '0;
            a1[c] <= '0;
            a2[c] <= '0;
            a3[c] <= '0;
            d2[c] <= '0;
            p3[c] <= '0;
         end
      end else if (adv) begin
         vld   <= {vld[2:0], s_valid};
         lst   <= {lst[2:0], s_valid & s_last};
         t1    <= (t_est < TMIN_T) ? TMIN_T : t_est;
         i1[0] <= red_pixel;
         i1[1] <= green_pixel;
         i1[2] <= blue_pixel;
         a1[0] <= ar;
         a1[1] <= ag;
         a1[2] <= ab;
         for (int unsigned c = 0; c < 3; c++) begin
            d2[c] <= $signed({1'b0, i1[c]}) - $signed({1'b0, a1[c]});
            a2[c] <= a1[c];
            p3[c] <= P_W'(d2[c]) * P_W'($signed({1'b0, inv}));
            a3[c] <= a2[c];
         end
         o_red   <= clamp8(q4[0]);
         o_green <= clamp8(q4[1]);
         o_blue  <= clamp8(q4[2]);
      end
   end

   // Counter holds the index of the next output beat within the frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt          <= '0;
         o_frame_done <= 1'b0;
         o_len_err    <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         if (m_valid && m_ready) begin
            if (m_last) begin
               o_frame_done <= 1'b1;
               cnt          <= '0;
               if (cnt != LAST_IDX)
                  o_len_err <= 1'b1;
            end else if (cnt == LAST_IDX) begin
               o_len_err <= 1'b1;
               cnt       <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dehaze_recover.sv
// Bench for dehaze_recover: arithmetic reference model, scoreboard queue, directed and random streams.
module tb_dehaze_recover;

   localparam int FP = 4;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  red_pixel = '0, green_pixel = '0, blue_pixel = '0;
   logic [7:0]  ar = '0, ag = '0, ab = '0;
   logic [11:0] t_est = '0;
   logic        s_last = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [7:0]  o_red, o_green, o_blue;
   logic        m_last, o_frame_done, o_len_err;

   always #5 i_clk = ~i_clk;

   dehaze_recover #(
      .TMIN      (410),
      .FRAME_PIX (FP),
      .CNT_W     (3)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .red_pixel    (red_pixel),
      .green_pixel  (green_pixel),
      .blue_pixel   (blue_pixel),
      .ar           (ar),
      .ag           (ag),
      .ab           (ab),
      .t_est        (t_est),
      .s_last       (s_last),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .o_red        (o_red),
      .o_green      (o_green),
      .o_blue       (o_blue),
      .m_last       (m_last),
      .o_frame_done (o_frame_done),
      .o_len_err    (o_len_err)
   );

   typedef struct {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       last;
   } exp_t;

   exp_t       sb[$];
   int         errors = 0;
   int         checks = 0;
   int         m_cnt = 0;
   logic       m_err = 1'b0;
   logic       exp_fd = 1'b0;
   logic       hold = 1'b0;
   logic [7:0] hr, hg, hb;
   logic       hl;
   logic [7:0] got_r, got_g, got_b;
   int         fd_pulses = 0;
   int         pops = 0;
   int         rmode = 0;
   int         cyc = 0;
   logic       last_sf = 1'b0;

   function automatic logic [7:0] ref_ch(int i, int a, int t);
      int tt, inv, p, f, j;
      tt  = (t < 410) ? 410 : t;
      inv = 1048576 / tt;
      p   = (i - a) * inv;
      f   = (p >= 0) ? p / 256 : -((-p + 255) / 256);
      j   = f + a;
      if (j < 0) j = 0;
      if (j > 255) j = 255;
      return 8'(j);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      exp_t e;
      logic mf, sf, nerr, nfd;
      int   ncnt;
      case (rmode)
         0: m_ready = 1'b1;
         1: m_ready = (cyc % 3 == 0);
         2: m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b0;
      endcase
      cyc++;
      @(negedge i_clk);
      mf   = m_valid && m_ready && !i_rst;
      sf   = s_valid && s_ready && !i_rst;
      nfd  = 1'b0;
      ncnt = m_cnt;
      nerr = m_err;
      if (!i_rst) begin
         chk("frame_done", 32'(o_frame_done), 32'(exp_fd));
         chk("len_err", 32'(o_len_err), 32'(m_err));
         if (o_frame_done) fd_pulses++;
         if (hold) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_r", 32'(o_red), 32'(hr));
            chk("hold_g", 32'(o_green), 32'(hg));
            chk("hold_b", 32'(o_blue), 32'(hb));
            chk("hold_last", 32'(m_last), 32'(hl));
         end
      end
      if (mf) begin
         if (sb.size() == 0) begin
            chk("extra_beat", 32'(m_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            pops++;
            chk("out_r", 32'(o_red), 32'(e.r));
            chk("out_g", 32'(o_green), 32'(e.g));
            chk("out_b", 32'(o_blue), 32'(e.b));
            chk("out_last", 32'(m_last), 32'(e.last));
            got_r = o_red;
            got_g = o_green;
            got_b = o_blue;
            if (e.last) begin
               nfd  = 1'b1;
               ncnt = 0;
               if (m_cnt != FP - 1) nerr = 1'b1;
            end else if (m_cnt == FP - 1) begin
               nerr = 1'b1;
               ncnt = 0;
            end else begin
               ncnt = m_cnt + 1;
            end
         end
      end
      hold = m_valid && !m_ready && !i_rst;
      hr = o_red;
      hg = o_green;
      hb = o_blue;
      hl = m_last;
      if (sf) begin
         e.r    = ref_ch(int'(red_pixel), int'(ar), int'(t_est));
         e.g    = ref_ch(int'(green_pixel), int'(ag), int'(t_est));
         e.b    = ref_ch(int'(blue_pixel), int'(ab), int'(t_est));
         e.last = s_last;
         sb.push_back(e);
      end
      last_sf = sf;
      @(posedge i_clk);
      #1;
      if (i_rst) begin
         sb.delete();
         m_cnt  = 0;
         m_err  = 1'b0;
         exp_fd = 1'b0;
         hold   = 1'b0;
      end else begin
         m_cnt  = ncnt;
         m_err  = nerr;
         exp_fd = nfd;
      end
   endtask

   task automatic put(logic [11:0] t, logic [7:0] r, logic [7:0] g, logic [7:0] b,
                      logic [7:0] xr, logic [7:0] xg, logic [7:0] xb, logic l);
      int n;
      s_valid = 1'b1;
      t_est = t;
      red_pixel = r;
      green_pixel = g;
      blue_pixel = b;
      ar = xr;
      ag = xg;
      ab = xb;
      s_last = l;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_sf && n < 200);
      if (!last_sf) chk("accept_timeout", 32'(last_sf), 32'd1);
   endtask

   task automatic drain();
      int n;
      s_valid = 1'b0;
      s_last = 1'b0;
      n = 0;
      while (sb.size() > 0 && n < 300) begin
         step();
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic stream(int nb, int last_at);
      for (int i = 0; i < nb; i++)
         put(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), i == last_at);
      drain();
   endtask

   task automatic reset_pulse();
      s_valid = 1'b0;
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
   endtask

   initial begin
      int p0;

      // Reset state
      reset_pulse();
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_o_red", 32'(o_red), 32'd0);
      chk("rst_o_green", 32'(o_green), 32'd0);
      chk("rst_o_blue", 32'(o_blue), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_frame_done", 32'(o_frame_done), 32'd0);
      chk("rst_len_err", 32'(o_len_err), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);

      // Latency: t=1.0 recovers I exactly, four registered stages
      rmode = 0;
      put(12'd4095, 8'd100, 8'd100, 8'd100, 8'd200, 8'd200, 8'd200, 1'b0);
      s_valid = 1'b0;
      chk("lat_edge1", 32'(m_valid), 32'd0);
      step();
      chk("lat_edge2", 32'(m_valid), 32'd0);
      step();
      chk("lat_edge3", 32'(m_valid), 32'd0);
      step();
      chk("lat_edge4", 32'(m_valid), 32'd1);
      chk("lat_red", 32'(o_red), 32'd100);
      chk("lat_green", 32'(o_green), 32'd100);
      chk("lat_blue", 32'(o_blue), 32'd100);
      drain();

      // Clamp high, clamp low, passthrough
      put(12'd2048, 8'd250, 8'd100, 8'd200, 8'd200, 8'd200, 8'd200, 1'b0);
      drain();
      chk("clamp_hi", 32'(got_r), 32'd255);
      chk("clamp_lo", 32'(got_g), 32'd0);
      chk("passthru", 32'(got_b), 32'd200);

      // Transmission floor, including t=0
      put(12'd100, 8'd201, 8'd201, 8'd201, 8'd200, 8'd200, 8'd200, 1'b0);
      drain();
      chk("tmin_r", 32'(got_r), 32'd209);
      chk("tmin_b", 32'(got_b), 32'd209);
      put(12'd0, 8'd201, 8'd201, 8'd201, 8'd200, 8'd200, 8'd200, 1'b0);
      drain();
      chk("t0_r", 32'(got_r), 32'd209);
      chk("t0_g", 32'(got_g), 32'd209);

      // Backpressure pattern 1,0,0 repeating
      rmode = 1;
      cyc = 0;
      p0 = pops;
      stream(8, -1);
      chk("stall_count", 32'(pops - p0), 32'd8);

      // Random backpressure, full-rate source
      rmode = 2;
      p0 = pops;
      stream(24, -1);
      chk("rand_count", 32'(pops - p0), 32'd24);

      // Correct frame length
      rmode = 0;
      reset_pulse();
      fd_pulses = 0;
      stream(4, 3);
      step();
      step();
      chk("frame_pulses", 32'(fd_pulses), 32'd1);
      chk("frame_len_ok", 32'(o_len_err), 32'd0);

      // Short frame sets the sticky error
      stream(2, 1);
      step();
      step();
      chk("short_len_err", 32'(o_len_err), 32'd1);
      stream(3, -1);
      step();
      chk("len_err_sticky", 32'(o_len_err), 32'd1);

      // Reset with three beats in flight
      rmode = 3;
      for (int i = 0; i < 3; i++)
         put(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'd128, 8'd128, 8'd128, i == 2);
      s_valid = 1'b0;
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      chk("flush_m_valid", 32'(m_valid), 32'd0);
      rmode = 0;
      fd_pulses = 0;
      for (int i = 0; i < 5; i++) step();
      chk("flush_no_done", 32'(fd_pulses), 32'd0);
      chk("flush_idle", 32'(m_valid), 32'd0);
      chk("flush_len_err", 32'(o_len_err), 32'd0);
      stream(4, 3);
      step();
      step();
      chk("post_rst_frame", 32'(fd_pulses), 32'd1);
      chk("post_rst_len", 32'(o_len_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
